// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the width/total helpers used by the
// timing generator and its per-axis counters.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 4;
    localparam int COLOR_W_DEF  = 4;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Never returns a zero width, even for degenerate one-entry ranges.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: counts 0..TOTAL-1 on each enable and decodes the
// active and sync regions of that axis.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = cnt_w(TOTAL)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // Region bounds carry one extra bit: SYNC_END may equal 2**W when BP=0.
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W:0] cnt_x;

    assign cnt_x  = {1'b0, cnt};
    assign wrap   = en && (cnt == LAST);
    assign active = (cnt_x < ACT_END);
    assign sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

    always_ff @(posedge clk) begin
        if (!clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, coordinate
// request stage and a one-tick registered output stage for sync/de/rgb.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = COLOR_W_DEF,
    localparam int XW      = cnt_w(H_ACTIVE),
    localparam int YW      = cnt_w(V_ACTIVE)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic                 req,
    output logic                 pix_ce,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 de
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          at_origin;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_ce = 1'b1;
        end else begin : g_div
            localparam int DW = cnt_w(CLK_DIV);
            localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
            logic [DW-1:0] div;

            always_ff @(posedge clk) begin
                if (!clr)
                    div <= '0;
                else
                    div <= (div == DLAST) ? '0 : div + DW'(1);
            end

            assign pix_ce = (div == DLAST);
        end
    endgenerate

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_hcnt (
        .clk    (clk),
        .clr    (clr),
        .en     (pix_ce),
        .cnt    (hcnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_vcnt (
        .clk    (clk),
        .clr    (clr),
        .en     (h_wrap),
        .cnt    (vcnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Tracks "counters sit at 0,0": set by reset and by the last-pixel wrap,
    // so frame_start needs no wide compare against hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (!clr)
            at_origin <= 1'b1;
        else if (pix_ce)
            at_origin <= v_wrap;
    end

    assign frame_start = clr && pix_ce && at_origin;

    assign req = h_active && v_active;
    assign x   = req ? XW'(hcnt) : '0;
    assign y   = req ? YW'(vcnt) : '0;

    always_ff @(posedge clk) begin
        if (!clr) begin
            de    <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else if (pix_ce) begin
            de          <= req;
            {r, g, b}   <= req ? rgb_in : '0;
            hsync       <= h_sync ? HS_POL : ~HS_POL;
            vsync       <= v_sync ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: small 16x8 timing at divide-by-2, plus a short
// divide-by-1 run at the default 640x480 timing.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [2:0]  x;
        logic [1:0]  y;
        logic        req;
        logic        fs;
        logic        de;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        clr_q = 1'b0;
    logic        lat_mode = 1'b1;
    logic [11:0] rgb_in;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        req, pix_ce, frame_start, hsync, vsync, de;
    logic [3:0]  r, g, b;

    logic        clr1 = 1'b0;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic        req1, pix_ce1, fs1, hsync1, vsync1, de1;
    logic [3:0]  r1, g1, b1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    initial forever #5 clk = ~clk;

    always @(posedge clk) clr_q <= clr;

    assign rgb_in = lat_mode ? {1'b0, x, 2'b00, y, 4'hA} : 12'hFFF;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4)
    ) dut (
        .clk(clk), .clr(clr), .rgb_in(rgb_in), .x(x), .y(y), .req(req),
        .pix_ce(pix_ce), .frame_start(frame_start), .hsync(hsync),
        .vsync(vsync), .r(r), .g(g), .b(b), .de(de)
    );

    vga_timing_gen #(
        .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .clr(clr1), .rgb_in(12'h000), .x(x1), .y(y1), .req(req1),
        .pix_ce(pix_ce1), .frame_start(fs1), .hsync(hsync1),
        .vsync(vsync1), .r(r1), .g(g1), .b(b1), .de(de1)
    );

    task automatic check(input bit ok, input string name, input int act, input int want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Expected view at pixel tick n after reset release (16x8 timing).
    function automatic exp_t model_tick(input int n, input bit lat);
        exp_t e;
        int   hc, vc, ph, pv;
        bit   pa;
        hc = n % 16;
        vc = (n / 16) % 8;
        e.req = (hc < 8) && (vc < 4);
        e.x   = e.req ? 3'(hc) : 3'd0;
        e.y   = e.req ? 2'(vc) : 2'd0;
        e.fs  = (hc == 0) && (vc == 0);
        if (n == 0) begin
            e.de = 1'b0; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
        end else begin
            ph = (n - 1) % 16;
            pv = ((n - 1) / 16) % 8;
            pa = (ph < 8) && (pv < 4);
            e.de  = pa;
            e.rgb = !pa ? 12'h000 : (lat ? {4'(ph), 4'(pv), 4'hA} : 12'hFFF);
            e.hs  = !((ph >= 10) && (ph < 12));
            e.vs  = (pv != 5);
        end
        return e;
    endfunction

    task automatic do_reset(input bit lat, input int ncyc);
        @(negedge clk);
        clr = 1'b0;
        lat_mode = lat;
        sb.delete();
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic push_ticks(input int n, input bit lat);
        for (int i = 0; i < n; i++) sb.push_back(model_tick(i, lat));
    endtask

    task automatic release_and_drain(input int budget);
        int cnt;
        cnt = 0;
        clr = 1'b1;
        while (sb.size() > 0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check(sb.size() == 0, "drain_timeout", sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t        e, a;
        logic [17:0] s1_hold;
        int          gap, fs_gap, de_cnt, hs_cnt, vs_cnt, mtick;
        bit          have_ce, have_fs, hold_ok;
        gap = 0; fs_gap = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; mtick = 0;
        have_ce = 0; have_fs = 0; hold_ok = 0; s1_hold = '0;
        forever begin
            @(negedge clk);
            if (!clr_q) begin
                check(!de && {r, g, b} == 12'h000 && hsync && vsync && !frame_start && !pix_ce,
                      "reset_state", int'({de, r, g, b, hsync, vsync, frame_start, pix_ce}), 12);
                have_ce = 0; have_fs = 0; hold_ok = 0; gap = 0; fs_gap = 0; mtick = 0;
            end else begin
                gap++;
                fs_gap++;
                if (pix_ce) begin
                    if (have_ce) check(gap == 2, "pix_ce_gap", gap, 2);
                    gap = 0;
                    have_ce = 1;
                    if (hold_ok)
                        check({de, r, g, b, hsync, vsync} == s1_hold[17:0] && s1_hold[17:16] == 2'b00 || {2'b00, de, r, g, b, hsync, vsync} == s1_hold,
                              "stage1_hold", int'({de, r, g, b, hsync, vsync}), int'(s1_hold));
                    hold_ok = 0;
                    if (frame_start) begin
                        if (have_fs) begin
                            check(fs_gap == 256, "frame_period_clk", fs_gap, 256);
                            check(de_cnt == 32, "de_ticks_per_frame", de_cnt, 32);
                            check(hs_cnt == 16, "hsync_low_ticks_per_frame", hs_cnt, 16);
                            check(vs_cnt == 16, "vsync_low_ticks_per_frame", vs_cnt, 16);
                        end
                        fs_gap = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
                        have_fs = 1;
                    end
                    de_cnt += int'(de);
                    hs_cnt += int'(!hsync);
                    vs_cnt += int'(!vsync);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        a.x = x; a.y = y; a.req = req; a.fs = frame_start; a.de = de;
                        a.rgb = {r, g, b}; a.hs = hsync; a.vs = vsync;
                        checks++;
                        if (a != e) begin
                            failures++;
                            $display("FAIL tick%0d: got x=%0d y=%0d req=%0b fs=%0b de=%0b rgb=%03h hs=%0b vs=%0b, want x=%0d y=%0d req=%0b fs=%0b de=%0b rgb=%03h hs=%0b vs=%0b",
                                     mtick, a.x, a.y, a.req, a.fs, a.de, a.rgb, a.hs, a.vs,
                                     e.x, e.y, e.req, e.fs, e.de, e.rgb, e.hs, e.vs);
                        end
                    end
                    mtick++;
                end else begin
                    check(!frame_start, "fs_off_tick", int'(frame_start), 0);
                    s1_hold = {2'b00, de, r, g, b, hsync, vsync};
                    hold_ok = 1;
                end
            end
        end
    end

    initial begin : stim
        int  cnt, fall1, fall2, bad_ce;
        bit  found, hs_prev;

        // Free-run with the coordinate-echo source: two full frames and a bit.
        do_reset(1'b1, 4);
        push_ticks(260, 1'b1);
        release_and_drain(700);

        // Blanking: white source must never leak outside the active area.
        do_reset(1'b0, 3);
        push_ticks(140, 1'b0);
        release_and_drain(400);

        // Mid-frame reset at hcnt=5, vcnt=2.
        do_reset(1'b1, 3);
        push_ticks(38, 1'b1);
        clr = 1'b1;
        found = 0;
        cnt = 0;
        while (!found && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (pix_ce && req && x == 3'd5 && y == 2'd2) found = 1;
        end
        check(found, "midframe_reach_5_2", int'(found), 1);
        clr = 1'b0;
        @(negedge clk);
        check(!de && {r, g, b} == 12'h000 && hsync && vsync && !frame_start,
              "midframe_reset_next_edge", int'({de, r, g, b, hsync, vsync, frame_start}), 6);
        repeat (2) @(negedge clk);
        sb.delete();
        push_ticks(40, 1'b1);
        release_and_drain(200);

        // Divide-by-one at default 640x480 timing.
        check(!de1 && hsync1 && vsync1 && !fs1 && {r1, g1, b1} == 12'h000,
              "div1_reset_state", int'({de1, hsync1, vsync1, fs1}), 6);
        @(negedge clk);
        clr1 = 1'b1;
        #1;
        check(fs1 && req1 && x1 == 10'd0 && y1 == 9'd0, "div1_first_tick",
              int'({fs1, req1, x1, y1}), int'({1'b1, 1'b1, 10'd0, 9'd0}));
        bad_ce = 0; fall1 = -1; fall2 = -1; hs_prev = hsync1;
        for (int c = 1; c <= 1700; c++) begin
            @(posedge clk);
            #1;
            if (!pix_ce1) bad_ce++;
            if (c == 639) check(req1 && x1 == 10'd639, "div1_last_active_x", int'(x1), 639);
            if (c == 640) check(!req1 && x1 == 10'd0, "div1_hblank_x", int'({req1, x1}), 0);
            if (c == 800) check(req1 && x1 == 10'd0 && y1 == 9'd1, "div1_line_800clk",
                                int'(y1), 1);
            if (hs_prev && !hsync1) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            hs_prev = hsync1;
        end
        check(bad_ce == 0, "div1_pix_ce_const", bad_ce, 0);
        check(fall1 == 657, "div1_hsync_first_fall", fall1, 657);
        check(fall2 - fall1 == 800, "div1_hsync_period", fall2 - fall1, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
